// File: rtl/dram_tx_pkg.sv
// dram_tx_pkg
// Shared definitions for the DRAM-to-UART output stage:
//   - state_t              : streamer / serializer state encoding
//   - DATA_BITS, STOP_BITS : 8N1 frame shape
//   - DEFAULT_CLKS_PER_BIT : baud divisor for a 50 MHz clock at 9600 baud
package dram_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  localparam int SYS_CLK_HZ           = 50_000_000;
  localparam int BAUD_RATE            = 9600;
  localparam int DEFAULT_CLKS_PER_BIT = SYS_CLK_HZ / BAUD_RATE;

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Sends one 8N1 frame per accepted load: start bit, DATA_BITS data bits
// LSB first, STOP_BITS stop bits, each CLKS_PER_BIT clocks long.
//
// Handshake: load/ready. ready is high while the serializer is idle; a
// cycle with load=1 and ready=1 captures data and the start bit begins on
// the next cycle. load while ready=0 is ignored.
//
// Ports:
//   clock, reset_n : system clock, synchronous active-low reset
//   load, data     : frame request and the byte to send
//   ready          : idle, able to accept load
//   phase_nxt      : phase the serializer takes at the next edge
//                    (ST_IDLE/ST_START/ST_DATA/ST_STOP), lets the parent
//                    track frame progress without a lag cycle
//   tx             : registered serial line, idle high
module uart_tx_serializer
  import dram_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output state_t               phase_nxt,
  output logic                 tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] LAST_TICK = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  state_t               phase;
  logic [BW-1:0]        baud_cnt, baud_nxt;
  logic [2:0]           bit_idx, idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 tx_nxt;
  logic                 tick;

  assign ready = (phase == ST_IDLE);
  assign tick  = (baud_cnt == LAST_TICK);

  always_comb begin
    phase_nxt = phase;
    baud_nxt  = baud_cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift;
    tx_nxt    = tx;
    case (phase)
      ST_START: begin
        if (tick) begin
          phase_nxt = ST_DATA;
          baud_nxt  = '0;
          idx_nxt   = '0;
          tx_nxt    = shift[0];
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          baud_nxt = '0;
          if (bit_idx == LAST_DATA) begin
            phase_nxt = ST_STOP;
            idx_nxt   = '0;
            tx_nxt    = 1'b1;
          end else begin
            // Shift now; the bit that moves into position 0 drives the line.
            idx_nxt   = bit_idx + 1'b1;
            shift_nxt = shift >> 1;
            tx_nxt    = shift[1];
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        tx_nxt = 1'b1;
        if (tick) begin
          baud_nxt = '0;
          if (bit_idx == LAST_STOP) begin
            phase_nxt = ST_IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = bit_idx + 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: begin
        // Idle; any unexpected encoding also recovers here.
        phase_nxt = ST_IDLE;
        baud_nxt  = '0;
        idx_nxt   = '0;
        tx_nxt    = 1'b1;
        if (load) begin
          phase_nxt = ST_START;
          shift_nxt = data;
          tx_nxt    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      phase    <= phase_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= idx_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
    end
  end

endmodule

// File: rtl/dram_tx_streamer.sv
// dram_tx_streamer
// On a rising edge of start_Tx, reads NUM_BYTES bytes from data DRAM
// starting at BASE_ADDR and sends each one as an 8N1 UART frame.
// Per byte: READ (address settles), LOAD (capture into serializer),
// START/DATA/STOP (serializer running), NEXT (advance or finish).
//
// Ports:
//   clock, reset_n : system clock, synchronous active-low reset
//   start_Tx       : level from the control FSM; only its rising edge counts
//   dram_rdata     : registered DRAM read data, valid 1 cycle after dram_addr
//   dram_addr      : registered DRAM read address
//   tx             : UART serial line, idle high
//   tx_busy        : run in progress (start edge until last stop bit ends)
//   tx_done        : sticky, set when the last byte completes; cleared by
//                    the next run start
module dram_tx_streamer
  import dram_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_WIDTH   = 16,
  parameter int BASE_ADDR    = 0,
  parameter int NUM_BYTES    = 16384
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start_Tx,
  input  logic [7:0]            dram_rdata,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  // One extra bit so a count of 2^ADDR_WIDTH bytes is representable.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [CW-1:0]         LAST_CNT = CW'(NUM_BYTES - 1);

  state_t        state;
  logic          start_q;
  logic          start_edge;
  logic [CW-1:0] byte_cnt;

  logic          ser_load;
  logic          ser_ready;
  state_t        ser_phase_nxt;

  // start_Tx stays high in the controller's end state, so only the edge
  // may launch a run.
  assign start_edge = start_Tx & ~start_q;
  assign ser_load   = (state == ST_LOAD) && ser_ready;

  uart_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_ser (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (ser_load),
    .data      (dram_rdata),
    .ready     (ser_ready),
    .phase_nxt (ser_phase_nxt),
    .tx        (tx)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      start_q   <= 1'b0;
      dram_addr <= BASE;
      byte_cnt  <= '0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      start_q <= start_Tx;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            dram_addr <= BASE;
            byte_cnt  <= '0;
            tx_done   <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= ST_READ;
          end
        end
        ST_READ: state <= ST_LOAD;
        ST_LOAD: begin
          if (ser_ready) state <= ST_START;
        end
        ST_START, ST_DATA, ST_STOP: begin
          // Mirror the serializer; its return to idle ends the frame.
          if (ser_phase_nxt == ST_IDLE) state <= ST_NEXT;
          else                          state <= ser_phase_nxt;
        end
        ST_NEXT: begin
          if (byte_cnt == LAST_CNT) begin
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            state   <= ST_DONE;
          end else begin
            dram_addr <= dram_addr + 1'b1;
            byte_cnt  <= byte_cnt + 1'b1;
            state     <= ST_READ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
